// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART link: receiver state encoding,
// default frame geometry and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// level both flops take during reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= {2{RST_VAL}};
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling on an oversampled tick. Recovers each bit at
// mid-bit and hands the byte over on a rdy/rdy_clr handshake.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  // Set after a low stop bit: wait for the line to recover before re-arming.
  logic                 brk_q, brk_d;

  uart_sync2 #(.RST_VAL(IDLE_LVL)) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    brk_d   = brk_q;

    if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (rx_s == START_LVL) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            bit_d = '0;
            state_d = (rx_s == START_LVL) ? DATA : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
            cnt_d = '0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (brk_q) begin
            if (rx_s == STOP_LVL) begin
              brk_d   = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s == STOP_LVL) begin
              data_d  = sh_q;
              rdy_d   = 1'b1;
              ferr_d  = 1'b0;
              // A simultaneous host clear wins over the overrun flag.
              if (rdy_q && !rdy_clr) ovr_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d = 1'b1;
              brk_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          brk_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + random bench for uart_receiver; the line is driven by a
// behavioural transmitter and results compared against a frame-level model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, busy;

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level model of the host-visible state.
  logic [7:0] m_data = 8'h00;
  logic       m_rdy = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Oversample tick every other clock, changed away from the active edge.
  initial forever begin
    @(negedge clk);
    clk_en = ~clk_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      do @(posedge clk); while (clk_en !== 1'b1);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_busy);
    chk({tag, ".data"}, 32'(data), 32'(m_data));
    chk({tag, ".rdy"}, 32'(rdy), 32'(m_rdy));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic host_clear();
    rdy_clr = 1'b1;
    @(posedge clk);
    #1 rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Transmit one 8N1 frame, 16 ticks per bit. clr_at_done raises rdy_clr
  // for the single clock in which the stop-bit mid-sample is taken.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr_at_done);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop;
    if (clr_at_done) begin
      tick(9);
      @(posedge clk);
      #1 rdy_clr = 1'b1;
      @(posedge clk);
      #1 rdy_clr = 1'b0;
      tick(6);
    end else begin
      tick(16);
    end
    if (stop) begin
      m_ovr  = clr_at_done ? 1'b0 : (m_rdy | m_ovr);
      m_data = b;
      m_rdy  = 1'b1;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rb;

    // Reset state
    #1;
    chk_all("reset", 1'b0);
    tick(4);
    reset = 1'b1;
    tick(4);
    chk_all("post_reset", 1'b0);

    // Loopback single byte, then host clear
    send_frame(8'hA5, 1'b1, 1'b0);
    chk_all("a5", 1'b0);
    host_clear();
    chk("a5_clr.rdy", 32'(rdy), 32'(m_rdy));

    // Back-to-back frames with a clear after each
    foreach (m_data[i]) ; // no-op keeps loop var style local
    for (int k = 0; k < 3; k++) begin
      logic [7:0] bb;
      bb = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h3C;
      send_frame(bb, 1'b1, 1'b0);
      chk_all($sformatf("b2b%0d", k), 1'b0);
      host_clear();
    end

    // Short low glitch while idle
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(1);
    chk("glitch.busy_mid", 32'(busy), 32'd1);
    tick(15);
    chk_all("glitch", 1'b0);

    // Low stop bit followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0);
    tick(48);
    chk_all("break", 1'b1);
    rx = 1'b1;
    tick(4);
    chk_all("break_end", 1'b0);

    // Overrun, then a clear coinciding with completion
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    chk_all("ovr", 1'b0);
    send_frame(8'h56, 1'b1, 1'b1);
    chk_all("ovr_clr_race", 1'b0);
    host_clear();

    // Random bytes with random idle gaps
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      tick(int'($urandom_range(0, 20)));
      send_frame(rb, 1'b1, 1'b0);
      chk_all($sformatf("rand%0d", k), 1'b0);
      host_clear();
    end

    // Reset in the middle of data bit 4
    rb = 8'h9B;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      tick(16);
    end
    rx = rb[4];
    tick(8);
    reset = 1'b0;
    #1;
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    chk_all("mid_reset", 1'b0);
    rx = 1'b1;
    tick(20);
    reset = 1'b1;
    tick(20);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk_all("after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
